lc3_console_tx: RTL and testbench

Parametrised console output channel for the LC-3 system. It replaces the fixed DDR/DSR-to-UART path with a buffered one. The datapath writes characters via the DDR store strobe into a FIFO of configurable depth, and a UART serializer drains them with configurable data width, parity and stop bits. DSR is produced locally, so software polling sees "ready" while the FIFO has room rather than only when the line is idle.

---
 rtl/lc3_console_tx_if.sv | 26 ++
 rtl/lc3_console_tx.sv | 185 ++++++++++++++++++
 tb/tb_lc3_console_tx.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/lc3_console_tx_if.sv
// Bus bundle between the LC-3 datapath and the buffered console transmitter:
// DDR write side, DSR/status readback and the serial line itself.
interface lc3_console_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          ld_ddr;
    logic [15:0]   ddr_in;
    logic          clr_ovf;
    logic [15:0]   dsr;
    logic [CW-1:0] fifo_count;
    logic          o_Tx_Serial;
    logic          o_Tx_Active;
    logic          o_Overflow;

    modport master (
        output ld_ddr, ddr_in, clr_ovf,
        input  dsr, fifo_count, o_Tx_Serial, o_Tx_Active, o_Overflow
    );

    modport slave (
        input  ld_ddr, ddr_in, clr_ovf,
        output dsr, fifo_count, o_Tx_Serial, o_Tx_Active, o_Overflow
    );
endinterface

// File: rtl/lc3_console_tx.sv
// Buffered LC-3 console output: DDR stores land in a small FIFO that a UART
// serializer drains; DSR reports FIFO room instead of line idleness.
module lc3_console_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            i_Clk,
    input  logic            reset_,
    lc3_console_tx_if.slave bus
);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam int STOP_CYC = STOP_BITS * CLKS_PER_BIT;
    localparam int TW       = $clog2(STOP_CYC);
    localparam int BW       = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [1:0] rstSync_q;
    logic       rstN;

    // Assertion is immediate; release is delayed two edges so every flop leaves reset together.
    always_ff @(posedge i_Clk or negedge reset_) begin
        if (!reset_) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign rstN = rstSync_q[1];

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        head_q, tail_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q;
    logic                 full, empty, popEn, pushEn, ovfSet, stopDone;
    logic [DATA_BITS-1:0] headData;

    state_t               state_q;
    logic [TW-1:0]        timer_q;
    logic [BW-1:0]        bitIdx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 line_q;
    logic                 active_q;
    logic                 unusedBits;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign headData = mem_q[head_q];
    assign stopDone = (state_q == S_STOP) && (timer_q == TW'(STOP_CYC - 1));
    assign popEn    = !empty && ((state_q == S_IDLE) || stopDone);
    // A full FIFO still accepts a write when the serializer frees a slot on the same edge.
    assign pushEn   = bus.ld_ddr && (!full || popEn);
    assign ovfSet   = bus.ld_ddr && full && !popEn;
    assign count_d  = count_q + CW'(pushEn) - CW'(popEn);

    always_ff @(posedge i_Clk or negedge rstN) begin
        if (!rstN) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (pushEn) tail_q <= tail_q + AW'(1);
            if (popEn)  head_q <= head_q + AW'(1);
            count_q <= count_d;
            if (ovfSet) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (pushEn) mem_q[tail_q] <= bus.ddr_in[DATA_BITS-1:0];
    end

    always_ff @(posedge i_Clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            line_q   <= 1'b1;
            active_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    line_q   <= 1'b1;
                    active_q <= 1'b0;
                    timer_q  <= '0;
                    if (!empty) begin
                        shift_q  <= headData;
                        parity_q <= (^headData) ^ (PARITY == 2);
                        state_q  <= S_START;
                        line_q   <= 1'b0;
                        active_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
                        timer_q  <= '0;
                        bitIdx_q <= '0;
                        state_q  <= S_DATA;
                        line_q   <= shift_q[0];
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
                        timer_q <= '0;
                        if (bitIdx_q == BW'(DATA_BITS - 1)) begin
                            if (PARITY != 0) begin
                                state_q <= S_PARITY;
                                line_q  <= parity_q;
                            end else begin
                                state_q <= S_STOP;
                                line_q  <= 1'b1;
                            end
                        end else begin
                            bitIdx_q <= bitIdx_q + BW'(1);
                            shift_q  <= shift_q >> 1;
                            line_q   <= shift_q[1];
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_PARITY: begin
                    if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
                        timer_q <= '0;
                        state_q <= S_STOP;
                        line_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_STOP: begin
                    if (stopDone) begin
                        timer_q <= '0;
                        // Chain straight into the next start bit so queued text leaves with no idle gap.
                        if (!empty) begin
                            shift_q  <= headData;
                            parity_q <= (^headData) ^ (PARITY == 2);
                            state_q  <= S_START;
                            line_q   <= 1'b0;
                        end else begin
                            state_q  <= S_IDLE;
                            line_q   <= 1'b1;
                            active_q <= 1'b0;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    line_q   <= 1'b1;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign unusedBits      = ^bus.ddr_in;
    assign bus.o_Tx_Serial = line_q;
    assign bus.o_Tx_Active = active_q;
    assign bus.o_Overflow  = ovf_q;
    assign bus.fifo_count  = count_q;
    assign bus.dsr         = {!full, empty && (state_q == S_IDLE), ovf_q, 13'b0};
endmodule

// File: tb/tb_lc3_console_tx.sv
// Directed bench: 8N1, even and odd parity transmitters share one stimulus;
// the 8N1 unit also covers burst/full, overflow clear, back-to-back and reset.
module tb_lc3_console_tx;
    logic        clk;
    logic        reset_;
    logic        ldDdr;
    logic [15:0] ddrIn;
    logic        clrOvf;
    int          vectors;
    int          miscompares;

    logic [9:0]  frameA;
    logic [10:0] frameB;
    logic [10:0] frameC;
    logic        expA, expB, expC;
    logic [7:0]  char2;
    int          burstCount [5];

    lc3_console_tx_if #(.FIFO_DEPTH(4)) ifA ();
    lc3_console_tx_if #(.FIFO_DEPTH(4)) ifB ();
    lc3_console_tx_if #(.FIFO_DEPTH(4)) ifC ();

    assign ifA.ld_ddr  = ldDdr;
    assign ifA.ddr_in  = ddrIn;
    assign ifA.clr_ovf = clrOvf;
    assign ifB.ld_ddr  = ldDdr;
    assign ifB.ddr_in  = ddrIn;
    assign ifB.clr_ovf = clrOvf;
    assign ifC.ld_ddr  = ldDdr;
    assign ifC.ddr_in  = ddrIn;
    assign ifC.clr_ovf = clrOvf;

    lc3_console_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1))
        dutA (.i_Clk(clk), .reset_(reset_), .bus(ifA.slave));
    lc3_console_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1))
        dutB (.i_Clk(clk), .reset_(reset_), .bus(ifB.slave));
    lc3_console_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1))
        dutC (.i_Clk(clk), .reset_(reset_), .bus(ifC.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic ld, input logic [15:0] data, input logic clr);
        ldDdr  = ld;
        ddrIn  = data;
        clrOvf = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        frameA      = {1'b1, 8'h41, 1'b0};
        frameB      = {1'b1, 1'b0, 8'h41, 1'b0};
        frameC      = {1'b1, 1'b1, 8'h41, 1'b0};
        char2       = 8'h11;
        burstCount  = '{1, 1, 2, 3, 4};
        reset_      = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0);

        step(3);
        checkOutput("rst line", ifA.o_Tx_Serial, 1'b1);
        checkOutput("rst active", ifA.o_Tx_Active, 1'b0);
        checkOutput("rst count", ifA.fifo_count, 3'd0);
        checkOutput("rst ovf", ifA.o_Overflow, 1'b0);
        checkOutput("rst dsr", ifA.dsr, 16'hC000);
        reset_ = 1'b1;
        step(3);
        checkOutput("idle dsr", ifA.dsr, 16'hC000);
        checkOutput("idle line", ifA.o_Tx_Serial, 1'b1);

        // Single character 0x41 on all three transmitters.
        applyStimulus(1'b1, 16'h0041, 1'b0);
        step(1);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        checkOutput("push count", ifA.fifo_count, 3'd1);
        checkOutput("push line", ifA.o_Tx_Serial, 1'b1);
        checkOutput("push dsr", ifA.dsr, 16'h8000);
        step(1);
        checkOutput("pop count", ifA.fifo_count, 3'd0);
        checkOutput("pop dsr", ifA.dsr, 16'h8000);
        for (int t = 0; t < 45; t++) begin
            expA = (t < 40) ? frameA[t / 4] : 1'b1;
            expB = (t < 44) ? frameB[t / 4] : 1'b1;
            expC = (t < 44) ? frameC[t / 4] : 1'b1;
            checkOutput("8N1 line", ifA.o_Tx_Serial, expA);
            checkOutput("8N1 active", ifA.o_Tx_Active, t < 40);
            checkOutput("8E1 line", ifB.o_Tx_Serial, expB);
            checkOutput("8E1 active", ifB.o_Tx_Active, t < 44);
            checkOutput("8O1 line", ifC.o_Tx_Serial, expC);
            checkOutput("8O1 active", ifC.o_Tx_Active, t < 44);
            step(1);
        end
        checkOutput("done dsr A", ifA.dsr, 16'hC000);
        checkOutput("done dsr B", ifB.dsr, 16'hC000);
        checkOutput("done dsr C", ifC.dsr, 16'hC000);

        // Burst of five: the first pop frees a slot so all five fit.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'(16'h0010 + i), 1'b0);
            step(1);
            checkOutput("burst count", ifA.fifo_count, burstCount[i]);
        end
        checkOutput("full dsr", ifA.dsr, 16'h0000);
        checkOutput("full ovf", ifA.o_Overflow, 1'b0);
        checkOutput("full active", ifA.o_Tx_Active, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 16'(16'h0020 + i), 1'b0);
            step(1);
            checkOutput("ovf count", ifA.fifo_count, 3'd4);
            checkOutput("ovf flag", ifA.o_Overflow, 1'b1);
            checkOutput("ovf dsr", ifA.dsr, 16'h2000);
        end
        applyStimulus(1'b0, 16'h0000, 1'b1);
        step(1);
        checkOutput("clr ovf", ifA.o_Overflow, 1'b0);
        checkOutput("clr dsr", ifA.dsr, 16'h0000);
        applyStimulus(1'b1, 16'h0030, 1'b1);
        step(1);
        checkOutput("set wins", ifA.o_Overflow, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        step(1);
        checkOutput("clr again", ifA.o_Overflow, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0);

        // First frame dropped at E1; we are now 8 edges past it.
        step(31);
        checkOutput("stop bit", ifA.o_Tx_Serial, 1'b1);
        checkOutput("stop active", ifA.o_Tx_Active, 1'b1);
        checkOutput("stop count", ifA.fifo_count, 3'd4);
        applyStimulus(1'b1, 16'h0040, 1'b0);
        step(1);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        checkOutput("b2b start", ifA.o_Tx_Serial, 1'b0);
        checkOutput("pop+push count", ifA.fifo_count, 3'd4);
        checkOutput("pop+push ovf", ifA.o_Overflow, 1'b0);
        checkOutput("b2b active", ifA.o_Tx_Active, 1'b1);
        step(2);
        for (int k = 0; k < 4; k++) begin
            step(4);
            checkOutput("frame2 bit", ifA.o_Tx_Serial, char2[k]);
        end
        checkOutput("pre-reset count", ifA.fifo_count, 3'd4);

        // Reset in the middle of data bit 3.
        reset_ = 1'b0;
        #1;
        checkOutput("mid rst line", ifA.o_Tx_Serial, 1'b1);
        checkOutput("mid rst active", ifA.o_Tx_Active, 1'b0);
        checkOutput("mid rst count", ifA.fifo_count, 3'd0);
        checkOutput("mid rst dsr", ifA.dsr, 16'hC000);
        step(2);
        reset_ = 1'b1;
        for (int t = 0; t < 60; t++) begin
            step(1);
            checkOutput("post rst line", ifA.o_Tx_Serial, 1'b1);
            checkOutput("post rst active", ifA.o_Tx_Active, 1'b0);
        end
        checkOutput("post rst count", ifA.fifo_count, 3'd0);
        checkOutput("post rst dsr", ifA.dsr, 16'hC000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
